// File: rtl/loader_pkg.sv
// Shared constants for the instruction loader: FSM state encoding,
// default word geometry and the HALT instruction.
package loader_pkg;

  localparam int NB_DATA        = 32;
  localparam int NB_BYTE        = 8;
  localparam int BYTES_PER_WORD = NB_DATA / NB_BYTE;

  localparam logic [NB_DATA-1:0] HALT_INSTR = 32'hFFFF_FFFF;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t RECV  = 2'd1;
  localparam state_t WRITE = 2'd2;
  localparam state_t DONE  = 2'd3;

endpackage

// File: rtl/byte_assembler.sv
// Packs incoming bytes MSB-first into a word; flags the byte that completes it.
// word_ready and word are combinational so the parent can register them on the completing edge.
module byte_assembler #(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               byte_valid,
  input  logic [NB_BYTE-1:0] byte_data,
  output logic               word_ready,
  output logic [NB_DATA-1:0] word
);

  localparam int WORD_BYTES = NB_DATA / NB_BYTE;
  localparam int CNT_W      = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  logic [NB_DATA-1:0] asm_reg;
  logic [CNT_W-1:0]   cnt_reg;

  // Shifting by a whole byte keeps this legal even when the word is one byte wide.
  assign word       = (asm_reg << NB_BYTE) | NB_DATA'(byte_data);
  assign word_ready = byte_valid && (cnt_reg == CNT_W'(WORD_BYTES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_reg <= '0;
      cnt_reg <= '0;
    end else if (clear) begin
      asm_reg <= '0;
      cnt_reg <= '0;
    end else if (byte_valid) begin
      asm_reg <= word;
      cnt_reg <= word_ready ? '0 : cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Loads a program from the debug UART into instruction memory, one word per
// write, stopping on HALT or when memory is full.
module instruction_loader #(
  parameter int                 NB_DATA    = loader_pkg::NB_DATA,
  parameter int                 NB_BYTE    = loader_pkg::NB_BYTE,
  parameter int                 NB_ADDR    = 10,
  parameter logic [NB_DATA-1:0] HALT_INSTR = loader_pkg::HALT_INSTR
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic               o_imem_wr_enb,
  output logic [NB_ADDR-1:0] o_imem_wr_addr,
  output logic [NB_DATA-1:0] o_imem_wr_data,
  output logic               o_busy,
  output logic               o_load_done,
  output logic               o_overflow,
  output logic [NB_ADDR:0]   o_word_count
);

  import loader_pkg::*;

  localparam logic [NB_ADDR-1:0] ADDR_MAX = {NB_ADDR{1'b1}};

  state_t             state_reg, state_next;
  logic [NB_ADDR-1:0] addr_reg;
  logic [NB_ADDR:0]   word_count_reg;
  logic               wr_enb_reg;
  logic [NB_ADDR-1:0] wr_addr_reg;
  logic [NB_DATA-1:0] wr_data_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               overflow_reg;

  logic               clear;
  logic               accept_en;
  logic               set_overflow;
  logic               word_ready;
  logic [NB_DATA-1:0] word_next;

  byte_assembler #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_byte_assembler (
    .clk        (i_clock),
    .rst        (i_reset),
    .clear      (clear),
    .byte_valid (accept_en && i_rx_valid),
    .byte_data  (i_rx_data),
    .word_ready (word_ready),
    .word       (word_next)
  );

  always_comb begin
    state_next   = state_reg;
    clear        = 1'b0;
    accept_en    = 1'b0;
    set_overflow = 1'b0;
    case (state_reg)
      IDLE: begin
        clear = 1'b1;
        if (i_start) state_next = RECV;
      end
      RECV: begin
        accept_en = 1'b1;
        if (word_ready) state_next = WRITE;
      end
      WRITE: begin
        // Bytes arriving during the write cycle start the next word.
        accept_en = 1'b1;
        if (wr_data_reg == HALT_INSTR) begin
          state_next = DONE;
        end else if (addr_reg == ADDR_MAX) begin
          state_next   = DONE;
          set_overflow = 1'b1;
        end else begin
          state_next = RECV;
        end
      end
      default: begin
        if (i_start) begin
          clear      = 1'b1;
          state_next = RECV;
        end
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      word_count_reg <= '0;
      wr_enb_reg     <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      busy_reg   <= (state_next == RECV) || (state_next == WRITE);
      done_reg   <= (state_next == DONE);
      wr_enb_reg <= (state_reg == RECV) && word_ready;

      if ((state_reg == RECV) && word_ready) begin
        wr_addr_reg <= addr_reg;
        wr_data_reg <= word_next;
      end

      if (clear) begin
        addr_reg       <= '0;
        word_count_reg <= '0;
        overflow_reg   <= 1'b0;
      end else if (state_reg == WRITE) begin
        word_count_reg <= word_count_reg + 1'b1;
        // Hold the address at the top so it never wraps back to 0.
        if (addr_reg != ADDR_MAX) addr_reg <= addr_reg + 1'b1;
        if (set_overflow) overflow_reg <= 1'b1;
      end
    end
  end

  assign o_imem_wr_enb  = wr_enb_reg;
  assign o_imem_wr_addr = wr_addr_reg;
  assign o_imem_wr_data = wr_data_reg;
  assign o_busy         = busy_reg;
  assign o_load_done    = done_reg;
  assign o_overflow     = overflow_reg;
  assign o_word_count   = word_count_reg;

endmodule
